// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational picoMIPS ALU between two requesters. A winner is
//   picked round-robin, its operands and function code are registered onto
//   the ALU ports, the ALU output is captured one cycle later, and the
//   captured result/flags are held in a response register until accepted.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid[1:0]          per-requester request valid (bit i = requester i)
//   req_ready[1:0]          per-requester accept, at most one bit set
//   req_a0/b0/func0         requester 0 operands and function code
//   req_a1/b1/func1         requester 1 operands and function code
//   alu_a/alu_b/alu_func    registered drive to the ALU
//   alu_result/alu_flags    ALU outputs, flags are {V,N,Z,C}
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rsp_flags      captured ALU result and flags
//   rsp_id                  requester that owns the response
//   busy                    high whenever the FSM is not idle
//   dbg_state               current FSM state, for observation only
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. On the request side, req_ready is raised only for a requester
// whose req_valid is already 1, so req_ready alone marks the transfer. On the
// response side, rsp_valid stays high and rsp_data/rsp_flags/rsp_id stay
// constant until an edge with rsp_ready=1 consumes the response.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [n-1:0] req_a0,
  input  logic [n-1:0] req_b0,
  input  logic [2:0]   req_func0,
  input  logic [n-1:0] req_a1,
  input  logic [n-1:0] req_b1,
  input  logic [2:0]   req_func1,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [2:0]   alu_func,
  input  logic [n-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_id,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [n-1:0] alu_a_q, alu_a_d;
  logic [n-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_func_q, alu_func_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [n-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_id_q, rsp_id_d;

  logic         win;
  logic         grant;

  // With both requesting, the one not served last wins; otherwise the
  // single valid requester wins. Meaningless when nobody requests.
  always_comb begin
    if (req_valid == 2'b11) win = ~last_grant_q;
    else                    win = req_valid[1];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_func_d   = alu_func_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_id_d     = rsp_id_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant        = 1'b1;
          alu_a_d      = win ? req_a1    : req_a0;
          alu_b_d      = win ? req_b1    : req_b0;
          alu_func_d   = win ? req_func1 : req_func0;
          rsp_id_d     = win;
          last_grant_d = win;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_result;
        rsp_flags_d = alu_flags;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to idle without a response.
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Gated by reset so no accept is ever shown while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (grant && !reset) req_ready = win ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_func_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_func_q   <= alu_func_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A local ALU function stands in for the
//   picoMIPS ALU. A transaction-level model (phase counter, last winner,
//   expected-response queue) predicts the outputs; a compare process checks
//   them every falling edge, and the directed sequences add hand-computed
//   literal checks.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [2:0] F_RA  = 3'd0;
  localparam logic [2:0] F_RB  = 3'd1;
  localparam logic [2:0] F_ADD = 3'd2;
  localparam logic [2:0] F_SUB = 3'd3;
  localparam logic [2:0] F_AND = 3'd4;
  localparam logic [2:0] F_OR  = 3'd5;
  localparam logic [2:0] F_XOR = 3'd6;
  localparam logic [2:0] F_UNK = 3'd7;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req_a0 = 8'h00, req_b0 = 8'h00, req_a1 = 8'h00, req_b1 = 8'h00;
  logic [2:0] req_func0 = 3'd0, req_func1 = 3'd0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_func;
  logic [3:0] alu_flags;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_id;
  logic       busy;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.n(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_func0(req_func0),
    .req_a1(req_a1), .req_b1(req_b1), .req_func1(req_func1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_id(rsp_id),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- stand-in ALU: returns {V,N,Z,C,result} ----------------
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] f);
    logic [8:0] w;
    logic [7:0] r;
    logic       v, c;
    v = 1'b0;
    c = 1'b0;
    case (f)
      F_RA:  r = a;
      F_RB:  r = b;
      F_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0];
        c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      F_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[7:0];
        c = w[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      F_AND: r = a & b;
      F_OR:  r = a | b;
      F_XOR: r = a ^ b;
      default: r = a;
    endcase
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_func);

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // phase: 0 idle, 1 operation in the ALU, 2 response offered
  int         phase = 0;
  int         m_last = 1;
  int         m_w;
  logic       m_id = 1'b0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [2:0] m_f = 3'd0;
  logic [12:0] exp_q[$];   // {id, V,N,Z,C, data}

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) return 1 - last;
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        phase  = 0;
        m_last = 1;
        m_id   = 1'b0;
        m_a    = 8'h00;
        m_b    = 8'h00;
        m_f    = 3'd0;
        exp_q.delete();
      end else begin
        case (phase)
          0: begin
            m_w = pick(req_valid, m_last);
            if (m_w == 0) begin
              m_a = req_a0; m_b = req_b0; m_f = req_func0;
            end else if (m_w == 1) begin
              m_a = req_a1; m_b = req_b1; m_f = req_func1;
            end
            if (m_w >= 0) begin
              m_last = m_w;
              m_id   = (m_w == 1);
              phase  = 1;
            end
          end
          1: begin
            exp_q.push_back({m_id, alu_fn(m_a, m_b, m_f)});
            phase = 2;
          end
          default: begin
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int         w;
    logic [1:0] exp_rr;
    forever begin
      @(negedge clk);
      w = (reset || phase != 0) ? -1 : pick(req_valid, m_last);
      exp_rr = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      chk("req_ready", req_ready, exp_rr);
      chk("busy", busy, phase != 0);
      chk("rsp_valid", rsp_valid, phase == 2);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_func", alu_func, m_f);
      if (phase == 2 && exp_q.size() > 0) begin
        chk("rsp_data", rsp_data, exp_q[0][7:0]);
        chk("rsp_flags", rsp_flags, exp_q[0][11:8]);
        chk("rsp_id", rsp_id, exp_q[0][12]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] f);
    if (i == 0) begin
      req_valid[0] = v; req_a0 = a; req_b0 = b; req_func0 = f;
    end else begin
      req_valid[1] = v; req_a1 = a; req_b1 = b; req_func1 = f;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits on falling edges for rsp_valid; returns the number of edges taken.
  task automatic wait_rsp(output int n_edges);
    n_edges = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        n_edges = k;
        break;
      end
    end
    if (n_edges == 0) chk("rsp_timeout", 0, 1);
  endtask

  // One isolated op: request, grant, response check, transfer.
  task automatic single_op(input string name, input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] f,
                           input logic [7:0] ed, input logic [3:0] ef);
    int n_edges;
    drive(i, 1'b1, a, b, f);
    @(negedge clk);
    chk({name, "_ready"}, req_ready, (i == 0) ? 2'b01 : 2'b10);
    tick();
    drive(i, 1'b0, a, b, f);
    wait_rsp(n_edges);
    chk({name, "_latency"}, n_edges, 2);
    chk({name, "_data"}, rsp_data, ed);
    chk({name, "_flags"}, rsp_flags, ef);
    chk({name, "_id"}, rsp_id, i);
    tick();
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    logic ids[$];
    int   cyc[$];
    int   n_edges;

    // reset state (checked during reset, asynchronously asserted at time 0)
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    do_reset();

    // basic ops
    single_op("t1_add", 0, 8'h7F, 8'h01, F_ADD, 8'h80, 4'b1100);
    single_op("t2_sub", 1, 8'h05, 8'h05, F_SUB, 8'h00, 4'b0010);
    single_op("t6_rb",  0, 8'h12, 8'hF0, F_RB,  8'hF0, 4'b0100);
    single_op("unk",    1, 8'h3A, 8'h99, F_UNK, 8'h3A, 4'b0000);

    // both requesting continuously after reset: alternating grants
    do_reset();
    drive(0, 1'b1, 8'h01, 8'h02, F_ADD);
    drive(1, 1'b1, 8'h09, 8'h04, F_SUB);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ids.push_back(rsp_id);
        cyc.push_back(c);
      end
    end
    tick();
    drive(0, 1'b0, 8'h01, 8'h02, F_ADD);
    drive(1, 1'b0, 8'h09, 8'h04, F_SUB);
    chk("t3_count", ids.size(), 4);
    for (int k = 0; k < ids.size() && k < 4; k++) begin
      chk("t3_id", ids[k], k % 2);
      chk("t3_cycle", cyc[k], 2 + 3 * k);
    end
    tick();
    tick();

    // back-pressure in RESP for 5 cycles with requester 1 waiting
    rsp_ready = 1'b0;
    drive(0, 1'b1, 8'hF0, 8'h3C, F_XOR);
    tick();
    drive(0, 1'b0, 8'hF0, 8'h3C, F_XOR);
    drive(1, 1'b1, 8'h11, 8'h22, F_ADD);
    wait_rsp(n_edges);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("t4_data", rsp_data, 8'hCC);
      chk("t4_flags", rsp_flags, 4'b0100);
      chk("t4_ready", req_ready, 2'b00);
      chk("t4_busy", busy, 1);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready", req_ready, 2'b10);
    tick();
    drive(1, 1'b0, 8'h11, 8'h22, F_ADD);
    wait_rsp(n_edges);
    chk("t4b_data", rsp_data, 8'h33);
    chk("t4b_id", rsp_id, 1);
    tick();

    // reset during EXEC
    drive(1, 1'b1, 8'h40, 8'h40, F_ADD);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_alu_a", alu_a, 8'h00);
    chk("t5_alu_b", alu_b, 8'h00);
    chk("t5_alu_func", alu_func, 3'd0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 8'h00);
    chk("t5_rsp_flags", rsp_flags, 4'h0);
    chk("t5_rsp_id", rsp_id, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", req_ready, 2'b00);
    tick();
    drive(1, 1'b0, 8'h40, 8'h40, F_ADD);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    drive(0, 1'b1, 8'h0F, 8'hF0, F_OR);
    drive(1, 1'b1, 8'hAA, 8'h0F, F_AND);
    @(negedge clk);
    chk("t5_first_grant", req_ready, 2'b01);
    tick();
    drive(0, 1'b0, 8'h0F, 8'hF0, F_OR);
    drive(1, 1'b0, 8'hAA, 8'h0F, F_AND);
    wait_rsp(n_edges);
    chk("t5_post_data", rsp_data, 8'hFF);
    chk("t5_post_id", rsp_id, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
